// File: rtl/intel_8257a.sv
// intel_8257a -- 8259A-style programmable interrupt controller, 8086 mode only.
//
// The controller latches requests from IR[7:0] into IRR. It masks them with
// IMR and resolves them by fixed priority, with IR0 highest. It uses full
// nesting against ISR to decide when to raise INT. The vector is supplied on
// the second INTA pulse. The controller can run alone, as a cascade master,
// or as a cascade slave.
//
// Ports:
//   clk     system clock, rising edge
//   reset   synchronous active-high reset
//   D       8-bit data bus; driven only during register reads and vector cycles
//   NRD     read strobe, active low
//   NWR     write strobe, active low
//   NCS     chip select, active low
//   A0      register address
//   NINTA   interrupt acknowledge, active low
//   NSP_EN  1 = master, 0 = slave (ignored in single mode)
//   IR      interrupt request lines
//   CAS     cascade ID bus; driven by a master during acknowledge, read by a slave
//   INT     interrupt request to the CPU, active high
//
// Build option:
//   PIC_AEOI_EN  when defined, ICW4 D1 enables automatic end-of-interrupt on
//                the second INTA rising edge. When undefined, only OCW2
//                clears ISR.

module intel_8257a (
  input  logic       clk,
  input  logic       reset,
  inout  logic [7:0] D,
  input  logic       NRD,
  input  logic       NWR,
  input  logic       NCS,
  input  logic       A0,
  input  logic       NINTA,
  input  logic       NSP_EN,
  input  logic [7:0] IR,
  inout  logic [2:0] CAS,
  output logic       INT
);

  typedef enum logic [2:0] {
    WAIT_ICW1,
    WAIT_ICW2,
    WAIT_ICW3,
    WAIT_ICW4,
    READY
  } init_t;

  typedef enum logic [1:0] {
    IA_IDLE,    // no acknowledge in progress
    IA_FIRST,   // first INTA low
    IA_GAP,     // between the two INTA pulses
    IA_SECOND   // second INTA low: vector on the bus
  } inta_t;

  init_t init_st, init_nx;
  inta_t ia_st, ia_nx;

  logic       nwr_q, nrd_q, ninta_q;
  logic [7:0] ir_q;
  logic [7:0] irr, isr, imr;
  logic [7:0] irr_nx, isr_nx, imr_nx;
  logic [4:0] base;
  logic [7:0] icw3;
  logic       ic4, sngl, ltim, rsel;
  logic [2:0] ack_id;
  logic       ack_valid;
  logic       int_q;
  logic       aeoi;

  logic       wr_stb, icw1_wr, ready_wr;
  logic       inta_fall, inta_rise, ack_now;
  logic [7:0] pending, prio_mask, irr_set;
  logic [2:0] pidx;
  logic       int_req;
  logic       master, slave;
  logic       cas_oe, vec_oe, rd_oe;
  logic [7:0] rd_data;

  // Returns the index of the highest-priority (lowest-numbered) set bit.
  // If no bit is set, it returns 7.
  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    lowest_idx = 3'd7;
    for (int unsigned i = 0; i < 8; i++)
      if (v[7 - i]) lowest_idx = 3'(7 - i);
  endfunction

  assign wr_stb    = ~nwr_q & NWR & ~NCS;
  assign icw1_wr   = wr_stb & ~A0 & D[4];
  assign ready_wr  = wr_stb & ~icw1_wr & (init_st == READY);
  assign inta_fall = ninta_q & ~NINTA;
  assign inta_rise = ~ninta_q & NINTA;
  assign ack_now   = (ia_st == IA_IDLE) & inta_fall;

  assign pending   = irr & ~imr;
  assign pidx      = lowest_idx(pending);
  // The mask covers every bit strictly above the highest in-service level.
  // A pending bit inside this mask may therefore interrupt the current
  // service routine.
  assign prio_mask = (isr == '0) ? '1 : ((isr & (~isr + 8'd1)) - 8'd1);
  assign int_req   = (init_st == READY) & (|(pending & prio_mask));

  assign irr_set   = ltim ? IR : (IR & ~ir_q);

  // Next-state logic for initialisation and for the INTA pulse sequence.
  always_comb begin
    init_nx = init_st;
    ia_nx   = ia_st;
    if (icw1_wr) begin
      init_nx = WAIT_ICW2;
    end else if (wr_stb & A0) begin
      unique case (init_st)
        WAIT_ICW2: init_nx = ~sngl ? WAIT_ICW3 : (ic4 ? WAIT_ICW4 : READY);
        WAIT_ICW3: init_nx = ic4 ? WAIT_ICW4 : READY;
        WAIT_ICW4: init_nx = READY;
        default:   init_nx = init_st;
      endcase
    end

    unique case (ia_st)
      IA_IDLE:   if (inta_fall) ia_nx = IA_FIRST;
      IA_FIRST:  if (inta_rise) ia_nx = IA_GAP;
      IA_GAP:    if (inta_fall) ia_nx = IA_SECOND;
      IA_SECOND: if (inta_rise) ia_nx = IA_IDLE;
      default:   ia_nx = IA_IDLE;
    endcase
    if (icw1_wr) ia_nx = IA_IDLE;
  end

  // Register next values. Acknowledge effects are applied before any write
  // in the same cycle, so an EOI sees the ISR bit that was just set.
  always_comb begin
    irr_nx = (irr | irr_set) & IR;
    isr_nx = isr;
    imr_nx = imr;

    if (ack_now && (pending != '0)) begin
      isr_nx[pidx] = 1'b1;
      irr_nx[pidx] = 1'b0;
    end
    // A spurious acknowledge (ack_valid=0) leaves ISR unchanged.
    if ((ia_st == IA_SECOND) && inta_rise && aeoi && ack_valid)
      isr_nx[ack_id] = 1'b0;

    if (icw1_wr) begin
      imr_nx = '0;
      isr_nx = '0;
    end else if (ready_wr) begin
      if (A0) begin
        imr_nx = D;
      end else if (!D[4] && !D[3]) begin
        unique case (D[7:5])
          3'b001:  isr_nx = isr_nx & ~(isr_nx & (~isr_nx + 8'd1));
          3'b011:  isr_nx[D[2:0]] = 1'b0;
          default: isr_nx = isr_nx;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      init_st   <= WAIT_ICW1;
      ia_st     <= IA_IDLE;
      nwr_q     <= 1'b1;
      nrd_q     <= 1'b1;
      ninta_q   <= 1'b1;
      ir_q      <= '0;
      irr       <= '0;
      isr       <= '0;
      imr       <= '0;
      base      <= '0;
      icw3      <= '0;
      ic4       <= 1'b0;
      sngl      <= 1'b0;
      ltim      <= 1'b0;
      rsel      <= 1'b0;
      ack_id    <= 3'd7;
      ack_valid <= 1'b0;
      int_q     <= 1'b0;
    end else begin
      init_st <= init_nx;
      ia_st   <= ia_nx;
      nwr_q   <= NWR;
      nrd_q   <= NRD;
      ninta_q <= NINTA;
      ir_q    <= icw1_wr ? '0 : IR;
      irr     <= irr_nx;
      isr     <= isr_nx;
      imr     <= imr_nx;
      int_q   <= int_req & (ia_nx == IA_IDLE);

      if (ack_now) begin
        ack_id    <= pidx;
        ack_valid <= (pending != '0);
      end

      if (icw1_wr) begin
        ic4  <= D[0];
        sngl <= D[1];
        ltim <= D[3];
        rsel <= 1'b0;
      end else if (wr_stb && A0) begin
        if (init_st == WAIT_ICW2) base <= D[7:3];
        if (init_st == WAIT_ICW3) icw3 <= D;
      end else if (ready_wr && !D[4] && D[3] && D[1]) begin
        rsel <= D[0];
      end
    end
  end

`ifdef PIC_AEOI_EN
  always_ff @(posedge clk) begin
    if (reset)
      aeoi <= 1'b0;
    else if (icw1_wr)
      aeoi <= 1'b0;
    else if (wr_stb && A0 && (init_st == WAIT_ICW4))
      aeoi <= D[1];
  end
`else
  assign aeoi = 1'b0;
`endif

  assign INT     = int_q;
  assign master  = ~sngl & NSP_EN;
  assign slave   = ~sngl & ~NSP_EN;
  assign cas_oe  = master & (ia_st != IA_IDLE);
  assign vec_oe  = (ia_st == IA_SECOND) &
                   (sngl | (master & ~icw3[ack_id]) | (slave & (CAS == icw3[2:0])));
  assign rd_oe   = ~nrd_q & ~NCS & NWR;
  assign rd_data = A0 ? imr : (rsel ? isr : irr);

  assign CAS = cas_oe ? ack_id : 'z;
  assign D   = vec_oe ? {base, ack_id} : (rd_oe ? rd_data : 'z);

endmodule

// File: tb/tb_intel_8257a.sv
// tb_intel_8257a -- self-checking bench for intel_8257a.
// Undriven bus lines are pulled up: an idle D reads as 0xFF and an idle
// CAS reads as 3'b111.

module tb_intel_8257a;

  logic       clk = 1'b0;
  logic       reset;
  logic       NRD, NWR, NCS, A0, NINTA, NSP_EN;
  logic [7:0] IR;
  logic       INT;
  wire  [7:0] D;
  wire  [2:0] CAS;
  logic [7:0] d_drv;
  logic       d_en;
  logic [2:0] cas_drv;
  logic       cas_en;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [7:0] m_isr, m_imr;
  logic [4:0] m_base;

  assign D   = d_en ? d_drv : 8'hzz;
  assign CAS = cas_en ? cas_drv : 3'bzzz;
  pullup (D[0]); pullup (D[1]); pullup (D[2]); pullup (D[3]);
  pullup (D[4]); pullup (D[5]); pullup (D[6]); pullup (D[7]);
  pullup (CAS[0]); pullup (CAS[1]); pullup (CAS[2]);

  always #5 clk = ~clk;

  intel_8257a dut (
    .clk(clk), .reset(reset), .D(D), .NRD(NRD), .NWR(NWR), .NCS(NCS),
    .A0(A0), .NINTA(NINTA), .NSP_EN(NSP_EN), .IR(IR), .CAS(CAS), .INT(INT)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic a, input logic [7:0] v);
    A0 = a; d_drv = v; d_en = 1'b1; NCS = 1'b0; NWR = 1'b0;
    tick(2);
    NWR = 1'b1;
    tick(2);
    NCS = 1'b1; d_en = 1'b0;
    tick(1);
  endtask

  task automatic rd(input logic a, output logic [7:0] v);
    A0 = a; NCS = 1'b0; NRD = 1'b0;
    tick(2);
    @(negedge clk);
    v = D;
    tick(1);
    NRD = 1'b1; NCS = 1'b1;
    tick(1);
  endtask

  // Full two-pulse acknowledge. CAS is sampled in the first low phase and
  // D in the second low phase.
  task automatic inta_seq(output logic [7:0] v, output logic [2:0] c);
    NINTA = 1'b0;
    tick(3);
    @(negedge clk);
    c = CAS;
    tick(1);
    NINTA = 1'b1;
    tick(3);
    NINTA = 1'b0;
    tick(3);
    @(negedge clk);
    v = D;
    tick(1);
    NINTA = 1'b1;
    tick(3);
  endtask

  // Index of the highest-priority set bit, or 8 if no bit is set.
  function automatic int first_set(input logic [7:0] v);
    for (int i = 0; i < 8; i++)
      if (v[i]) return i;
    return 8;
  endfunction

  task automatic test_reset;
    logic [7:0] v;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    @(negedge clk);
    checks++; if (INT !== 1'b0) begin errors++; $display("FAIL reset_int got=%b exp=0", INT); end
    checks++; if (D !== 8'hFF) begin errors++; $display("FAIL reset_d_hiz got=%h exp=ff(pulled)", D); end
    checks++; if (CAS !== 3'b111) begin errors++; $display("FAIL reset_cas_hiz got=%b exp=111(pulled)", CAS); end
    rd(1'b1, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_imr got=%h exp=00", v); end
    IR = 8'h08;
    tick(3);
    @(negedge clk);
    checks++; if (INT !== 1'b0) begin errors++; $display("FAIL preinit_int got=%b exp=0", INT); end
    IR = 8'h00;
    tick(2);
  endtask

  task automatic test_basic;
    logic [7:0] v;
    logic [2:0] c;
    wr(1'b0, 8'h13); wr(1'b1, 8'h40); wr(1'b1, 8'h01);
    IR = 8'h08;
    tick(2);
    @(negedge clk);
    checks++; if (INT !== 1'b1) begin errors++; $display("FAIL basic_int got=%b exp=1", INT); end
    inta_seq(v, c);
    checks++; if (v !== 8'h43) begin errors++; $display("FAIL basic_vector got=%h exp=43", v); end
    wr(1'b0, 8'h0B); rd(1'b0, v);
    checks++; if (v !== 8'h08) begin errors++; $display("FAIL basic_isr got=%h exp=08", v); end
    wr(1'b0, 8'h0A); rd(1'b0, v);
    checks++; if (v[3] !== 1'b0) begin errors++; $display("FAIL basic_irr3 got=%b exp=0", v[3]); end
  endtask

  task automatic test_nesting;
    logic [7:0] v;
    IR = 8'h28;
    tick(3);
    @(negedge clk);
    checks++; if (INT !== 1'b0) begin errors++; $display("FAIL nest_low_int got=%b exp=0", INT); end
    IR = 8'h2A;
    tick(3);
    @(negedge clk);
    checks++; if (INT !== 1'b1) begin errors++; $display("FAIL nest_high_int got=%b exp=1", INT); end
    wr(1'b0, 8'h20);
    wr(1'b0, 8'h0B); rd(1'b0, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL nseoi_isr got=%h exp=00", v); end
    IR = 8'h00;
    tick(3);
  endtask

  task automatic test_mask;
    logic [7:0] v;
    wr(1'b1, 8'hFF);
    IR = 8'h04;
    tick(3);
    @(negedge clk);
    checks++; if (INT !== 1'b0) begin errors++; $display("FAIL mask_int got=%b exp=0", INT); end
    wr(1'b0, 8'h0A); rd(1'b0, v);
    checks++; if (v !== 8'h04) begin errors++; $display("FAIL mask_irr got=%h exp=04", v); end
    rd(1'b1, v);
    checks++; if (v !== 8'hFF) begin errors++; $display("FAIL mask_imr got=%h exp=ff", v); end
    IR = 8'h00;
    wr(1'b1, 8'h00);
    tick(2);
  endtask

  task automatic test_spurious;
    logic [7:0] v;
    logic [2:0] c;
    inta_seq(v, c);
    checks++; if (v !== 8'h47) begin errors++; $display("FAIL spurious_vector got=%h exp=47", v); end
    wr(1'b0, 8'h0B); rd(1'b0, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL spurious_isr got=%h exp=00", v); end
  endtask

  task automatic test_level;
    logic [7:0] v;
    wr(1'b0, 8'h1B); wr(1'b1, 8'h40); wr(1'b1, 8'h01);
    IR = 8'h40;
    tick(3);
    rd(1'b0, v);
    checks++; if (v !== 8'h40) begin errors++; $display("FAIL level_irr got=%h exp=40", v); end
    @(negedge clk);
    checks++; if (INT !== 1'b1) begin errors++; $display("FAIL level_int got=%b exp=1", INT); end
    IR = 8'h00;
    tick(3);
    rd(1'b0, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL level_drop_irr got=%h exp=00", v); end
    @(negedge clk);
    checks++; if (INT !== 1'b0) begin errors++; $display("FAIL level_drop_int got=%b exp=0", INT); end
  endtask

  task automatic test_cascade;
    logic [7:0] v;
    logic [2:0] c;
    NSP_EN = 1'b1;
    wr(1'b0, 8'h11); wr(1'b1, 8'h20); wr(1'b1, 8'h04); wr(1'b1, 8'h01);
    IR = 8'h04;
    tick(3);
    @(negedge clk);
    checks++; if (INT !== 1'b1) begin errors++; $display("FAIL master_int got=%b exp=1", INT); end
    inta_seq(v, c);
    checks++; if (c !== 3'b010) begin errors++; $display("FAIL master_cas got=%b exp=010", c); end
    checks++; if (v !== 8'hFF) begin errors++; $display("FAIL master_d_hiz got=%h exp=ff(pulled)", v); end
    @(negedge clk);
    checks++; if (CAS !== 3'b111) begin errors++; $display("FAIL master_cas_release got=%b exp=111", CAS); end
    IR = 8'h00;
    tick(2);

    NSP_EN = 1'b0;
    wr(1'b0, 8'h11); wr(1'b1, 8'h20); wr(1'b1, 8'h02); wr(1'b1, 8'h01);
    cas_drv = 3'd2; cas_en = 1'b1;
    IR = 8'h20;
    tick(3);
    inta_seq(v, c);
    checks++; if (v !== 8'h25) begin errors++; $display("FAIL slave_vector got=%h exp=25", v); end
    IR = 8'h00;
    tick(2);
    cas_drv = 3'd3;
    IR = 8'h10;
    tick(3);
    inta_seq(v, c);
    checks++; if (v !== 8'hFF) begin errors++; $display("FAIL slave_other_id got=%h exp=ff(pulled)", v); end
    IR = 8'h00;
    cas_en = 1'b0;
    NSP_EN = 1'b1;
    tick(2);
  endtask

  task automatic test_aeoi;
    logic [7:0] v;
    logic [2:0] c;
    logic [7:0] exp_isr;
    wr(1'b0, 8'h13); wr(1'b1, 8'h40); wr(1'b1, 8'h03);
    IR = 8'h08;
    tick(3);
    inta_seq(v, c);
    checks++; if (v !== 8'h43) begin errors++; $display("FAIL aeoi_vector got=%h exp=43", v); end
`ifdef PIC_AEOI_EN
    exp_isr = 8'h00;
`else
    exp_isr = 8'h08;
`endif
    wr(1'b0, 8'h0B); rd(1'b0, v);
    checks++; if (v !== exp_isr) begin errors++; $display("FAIL aeoi_isr got=%h exp=%h", v, exp_isr); end
    IR = 8'h00;
    tick(2);
  endtask

  // Random masks, request patterns and EOIs, compared against a model that
  // applies the priority and nesting rules directly.
  task automatic test_random;
    logic [7:0] v, p, pend;
    logic [2:0] c;
    logic       exp_int;
    int         k;
    m_base = 5'($urandom_range(0, 31));
    m_isr  = 8'h00;
    wr(1'b0, 8'h13); wr(1'b1, {m_base, 3'b000}); wr(1'b1, 8'h01);
    for (int it = 0; it < 24; it++) begin
      m_imr = 8'($urandom) & 8'($urandom);
      wr(1'b1, m_imr);
      p = 8'($urandom_range(1, 255));
      IR = p;
      tick(3);
      pend = p & ~m_imr;
      exp_int = (pend != 8'h00) && (first_set(pend) < first_set(m_isr));
      @(negedge clk);
      checks++; if (INT !== exp_int) begin errors++; $display("FAIL rnd_int it=%0d got=%b exp=%b", it, INT, exp_int); end
      wr(1'b0, 8'h0A); rd(1'b0, v);
      checks++; if (v !== p) begin errors++; $display("FAIL rnd_irr it=%0d got=%h exp=%h", it, v, p); end
      rd(1'b1, v);
      checks++; if (v !== m_imr) begin errors++; $display("FAIL rnd_imr it=%0d got=%h exp=%h", it, v, m_imr); end
      if (exp_int) begin
        k = first_set(pend);
        inta_seq(v, c);
        checks++; if (v !== {m_base, 3'(k)}) begin errors++; $display("FAIL rnd_vector it=%0d got=%h exp=%h", it, v, {m_base, 3'(k)}); end
        m_isr[k] = 1'b1;
      end
      if ($urandom_range(0, 1) == 0) begin
        wr(1'b0, 8'h20);
        if (first_set(m_isr) < 8) m_isr[first_set(m_isr)] = 1'b0;
      end else begin
        k = $urandom_range(0, 7);
        wr(1'b0, 8'h60 | 8'(k));
        m_isr[k] = 1'b0;
      end
      wr(1'b0, 8'h0B); rd(1'b0, v);
      checks++; if (v !== m_isr) begin errors++; $display("FAIL rnd_isr it=%0d got=%h exp=%h", it, v, m_isr); end
      IR = 8'h00;
      tick(3);
    end
  endtask

  initial begin
    reset = 1'b1; NRD = 1'b1; NWR = 1'b1; NCS = 1'b1; A0 = 1'b0;
    NINTA = 1'b1; NSP_EN = 1'b1; IR = 8'h00;
    d_drv = 8'h00; d_en = 1'b0; cas_drv = 3'd0; cas_en = 1'b0;
    test_reset;
    test_basic;
    test_nesting;
    test_mask;
    test_spurious;
    test_level;
    test_cascade;
    test_aeoi;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
